// File: rtl/cdb_complete_arb_pkg.sv
// Shared types and default configuration for the CDB complete stage.
package cdb_complete_arb_pkg;

    localparam int unsigned DEF_NUM_SRC = 4;
    localparam int unsigned DEF_CDB_W   = 2;
    localparam int unsigned DEF_QDEPTH  = 4;
    localparam int unsigned DEF_XLEN    = 32;
    localparam int unsigned DEF_PREG_W  = 6;
    localparam int unsigned DEF_ROB_W   = 5;

    localparam logic [DEF_PREG_W-1:0] ZERO_PREG = '0;

    typedef struct packed {
        logic [DEF_PREG_W-1:0] tag;
        logic [DEF_ROB_W-1:0]  rob_idx;
        logic [DEF_XLEN-1:0]   value;
    } CDB_ENTRY;

    typedef struct packed {
        logic     valid;
        CDB_ENTRY entry;
    } CDB_PACKET;

    function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/cdb_complete_arb_src_queue.sv
// Single-source circular FIFO holding finished results awaiting a CDB lane.
module cm_src_queue #(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned W      = 43
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(QDEPTH):0]  count
);

    localparam int unsigned AW = $clog2(QDEPTH);

    logic [W-1:0]  mem [QDEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/cdb_complete_arb.sv
// Complete stage: per-source queues with bypass, round-robin grant onto CDB_W registered lanes.
module cdb_complete_arb
    import cdb_complete_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = DEF_NUM_SRC,
    parameter int unsigned CDB_W   = DEF_CDB_W,
    parameter int unsigned QDEPTH  = DEF_QDEPTH,
    parameter int unsigned XLEN    = DEF_XLEN,
    parameter int unsigned PREG_W  = DEF_PREG_W,
    parameter int unsigned ROB_W   = DEF_ROB_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rollback_en,
    input  logic [NUM_SRC-1:0]        ex_valid,
    input  logic [NUM_SRC-1:0]        ex_done,
    input  logic [NUM_SRC-1:0]        ex_take_branch,
    input  logic [NUM_SRC*PREG_W-1:0] ex_pdest,
    input  logic [NUM_SRC*ROB_W-1:0]  ex_rob_idx,
    input  logic [NUM_SRC*XLEN-1:0]   ex_result,
    input  logic [NUM_SRC*XLEN-1:0]   ex_npc,
    output logic [NUM_SRC-1:0]        ex_ready,
    output logic [CDB_W-1:0]          cdb_valid,
    output logic [CDB_W*PREG_W-1:0]   cdb_tag,
    output logic [CDB_W*ROB_W-1:0]    cdb_rob_idx,
    output logic [CDB_W*XLEN-1:0]     cdb_value
);

    localparam int unsigned EW = PREG_W + ROB_W + XLEN;
    localparam int unsigned CW = $clog2(QDEPTH) + 1;
    localparam int unsigned PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      rr_next;
    logic [CW-1:0]      q_count  [NUM_SRC];
    logic [EW-1:0]      q_head   [NUM_SRC];
    logic [EW-1:0]      in_entry [NUM_SRC];
    logic [NUM_SRC-1:0] accept;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] q_empty;
    logic [EW-1:0]      lane_entry [CDB_W];
    logic [CDB_W-1:0]   lane_valid;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign q_empty[i]  = (q_count[i] == '0);
        assign ex_ready[i] = (q_count[i] < CW'(QDEPTH));
        assign accept[i]   = ex_valid[i] & ex_done[i] & ex_ready[i];
        assign in_entry[i] = {ex_pdest[i*PREG_W +: PREG_W],
                              ex_rob_idx[i*ROB_W +: ROB_W],
                              ex_take_branch[i] ? ex_npc[i*XLEN +: XLEN]
                                                : ex_result[i*XLEN +: XLEN]};
        // A granted bypass never touches the queue; a granted head pops.
        assign pop[i]  = grant[i] & ~q_empty[i];
        assign push[i] = accept[i] & ~(grant[i] & q_empty[i]);

        cm_src_queue #(
            .QDEPTH (QDEPTH),
            .W      (EW)
        ) u_queue (
            .clock  (clock),
            .reset  (reset),
            .flush  (rollback_en),
            .push   (push[i]),
            .pop    (pop[i]),
            .din    (in_entry[i]),
            .head   (q_head[i]),
            .count  (q_count[i])
        );
    end

    always_comb begin
        int unsigned idx;
        int unsigned n;
        int unsigned last;
        grant      = '0;
        lane_valid = '0;
        n          = 0;
        last       = 0;
        idx        = 32'(rr_ptr);
        for (int unsigned k = 0; k < CDB_W; k++) begin
            lane_entry[k] = '0;
        end
        for (int unsigned off = 0; off < NUM_SRC; off++) begin
            if ((accept[idx] || !q_empty[idx]) && n < CDB_W) begin
                grant[idx]    = 1'b1;
                lane_valid[n] = 1'b1;
                lane_entry[n] = q_empty[idx] ? in_entry[idx] : q_head[idx];
                last          = idx;
                n             = n + 1;
            end
            idx = wrap_inc(idx, NUM_SRC);
        end
        rr_next = (n == 0) ? rr_ptr : PW'(wrap_inc(last, NUM_SRC));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr      <= '0;
            cdb_valid   <= '0;
            cdb_tag     <= '0;
            cdb_rob_idx <= '0;
            cdb_value   <= '0;
        end else begin
            rr_ptr    <= rollback_en ? '0 : rr_next;
            cdb_valid <= rollback_en ? '0 : lane_valid;
            for (int unsigned k = 0; k < CDB_W; k++) begin
                cdb_tag[k*PREG_W +: PREG_W]    <= lane_entry[k][EW-1 -: PREG_W];
                cdb_rob_idx[k*ROB_W +: ROB_W]  <= lane_entry[k][XLEN +: ROB_W];
                cdb_value[k*XLEN +: XLEN]      <= lane_entry[k][XLEN-1:0];
            end
        end
    end

endmodule
